// File: rtl/aes_collect_pkg.sv
// aes_collect_pkg: shared widths and serialiser state encoding for aes_result_collector.
package aes_collect_pkg;
   localparam int BLOCK_W = 128;
   localparam int WORD_W = 32;
   localparam int WORDS_PER_BLOCK = 4;
   typedef enum logic {IDLE, SEND} collect_state_t;
endpackage

// File: rtl/aes_collect_fifo.sv
// aes_collect_fifo: synchronous block FIFO; pointers carry an extra wrap bit so full/empty come from compare.
module aes_collect_fifo import aes_collect_pkg::*; #(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               push,
   input  logic               pop,
   input  logic [BLOCK_W-1:0] din,
   output logic [BLOCK_W-1:0] dout,
   output logic [AW:0]        count,
   output logic               full,
   output logic               empty
);
   logic [BLOCK_W-1:0] mem [DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   assign count = wr_ptr - rd_ptr;
   assign full = count == (AW+1)'(DEPTH);
   assign empty = wr_ptr == rd_ptr;
   assign dout = mem[rd_ptr[AW-1:0]];
   always_ff @(posedge clk) begin
      if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) wr_ptr <= wr_ptr + 1'b1;
         if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
      end
   end
endmodule

// File: rtl/aes_result_collector.sv
// aes_result_collector: captures AES result blocks on valid rise, buffers them, streams 32-bit words MSW first.
// Optional AES_COLLECT_PARITY_EN adds out_par = ^out_word.
module aes_result_collector import aes_collect_pkg::*; #(
   parameter int DEPTH = 4
) (
   input  logic                   AES_clk,
   input  logic                   AES_rst,
   input  logic                   AES_data_out_valid,
   input  logic [BLOCK_W-1:0]     AES_data_out,
   output logic [WORD_W-1:0]      out_word,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_last,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic                   overflow
`ifdef AES_COLLECT_PARITY_EN
   ,
   output logic                   out_par
`endif
);
   logic vld_d, cap, pop, full, empty;
   logic [BLOCK_W-1:0] head, shift_reg;
   logic [1:0] word_idx;
   collect_state_t state, state_nx;
   assign cap = AES_data_out_valid & ~vld_d;
   aes_collect_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk(AES_clk),
      .rst(AES_rst),
      .push(cap),
      .pop(pop),
      .din(AES_data_out),
      .dout(head),
      .count(fifo_count),
      .full(full),
      .empty(empty)
   );
   always_ff @(posedge AES_clk) begin
      if (AES_rst) begin
         vld_d <= 1'b0;
         overflow <= 1'b0;
      end else begin
         vld_d <= AES_data_out_valid;
         overflow <= overflow | (cap & full);
      end
   end
   always_comb begin
      pop = (state == IDLE) & ~empty;
      state_nx = (state == IDLE) ? (empty ? IDLE : SEND)
               : ((out_ready && word_idx == 2'(WORDS_PER_BLOCK-1)) ? IDLE : SEND);
   end
   // The shift register moves the next word into the top slot on every handshake.
   always_ff @(posedge AES_clk) begin
      if (AES_rst) begin
         state <= IDLE;
         shift_reg <= '0;
         word_idx <= '0;
      end else begin
         state <= state_nx;
         if (pop) begin
            shift_reg <= head;
            word_idx <= '0;
         end else if (state == SEND && out_ready) begin
            shift_reg <= {shift_reg[BLOCK_W-WORD_W-1:0], WORD_W'(0)};
            word_idx <= word_idx + 1'b1;
         end
      end
   end
   always_comb begin
      out_valid = state == SEND;
      out_word = out_valid ? shift_reg[BLOCK_W-1 -: WORD_W] : '0;
      out_last = out_valid && word_idx == 2'(WORDS_PER_BLOCK-1);
   end
`ifdef AES_COLLECT_PARITY_EN
   assign out_par = ^out_word;
`endif
endmodule
